// File: rtl/adder_responder.sv
// Buffered adder with valid/ready request and response channels; results leave in order.
// Define ADDER_RESPONDER_CARRY_EN to keep a carry bit per entry and drive resp_carry from it.
module adder_responder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_carry,
  output logic [7:0]       txn_cnt
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
`ifdef ADDER_RESPONDER_CARRY_EN
    logic             carry;
`endif
    logic [WIDTH-1:0] sum;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           wr_entry;
  entry_t           rd_entry;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  // Handshakes depend only on registered occupancy, so resp_ready never reaches req_ready.
  assign req_ready  = (count < CNT_W'(DEPTH));
  assign resp_valid = (count != '0);
  assign push       = req_valid && req_ready;
  assign pop        = resp_valid && resp_ready;

  always_comb begin
    wr_entry = '0;
`ifdef ADDER_RESPONDER_CARRY_EN
    {wr_entry.carry, wr_entry.sum} = {1'b0, req_a} + {1'b0, req_b};
`else
    wr_entry.sum = req_a + req_b;
`endif
  end

  // Empty buffer reads as zero so the outputs are defined straight out of reset.
  assign rd_entry = resp_valid ? mem[rd_ptr] : '0;
  assign resp_sum = rd_entry.sum;
`ifdef ADDER_RESPONDER_CARRY_EN
  assign resp_carry = rd_entry.carry;
`else
  assign resp_carry = 1'b0;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      txn_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        txn_cnt <= txn_cnt + 8'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_responder.sv
// Self-checking bench for adder_responder: queue-based reference model, directed pins, random traffic.
module tb_adder_responder;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int unsigned MASK = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [WIDTH-1:0] resp_sum;
  logic             resp_carry;
  logic [7:0]       txn_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned model_q[$];
  int unsigned model_cnt = 0;

  adder_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum),
    .resp_carry(resp_carry), .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int unsigned exp_carry(input int unsigned full);
`ifdef ADDER_RESPONDER_CARRY_EN
    return full >> WIDTH;
`else
    return 0 * full;
`endif
  endfunction

  task automatic compare_all();
    chk("req_ready", 32'(req_ready), 32'(model_q.size() < DEPTH));
    chk("resp_valid", 32'(resp_valid), 32'(model_q.size() != 0));
    chk("txn_cnt", 32'(txn_cnt), model_cnt % 256);
    if (model_q.size() != 0) begin
      chk("resp_sum", 32'(resp_sum), model_q[0] & MASK);
      chk("resp_carry", 32'(resp_carry), exp_carry(model_q[0]));
    end
  endtask

  // Called just after a falling edge; applies inputs for one rising edge, then checks at the next falling edge.
  task automatic step(input bit v, input int unsigned a, input int unsigned b, input bit rr);
    bit push, pop;
    req_valid  = v;
    req_a      = WIDTH'(a);
    req_b      = WIDTH'(b);
    resp_ready = rr;
    push = v && (model_q.size() < DEPTH);
    pop  = rr && (model_q.size() != 0);
    @(posedge clk);
    if (pop) begin
      void'(model_q.pop_front());
      model_cnt++;
    end
    if (push) model_q.push_back((a & MASK) + (b & MASK));
    @(negedge clk);
    compare_all();
    #1;
  endtask

  task automatic reset_checks();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_sum", 32'(resp_sum), 32'd0);
    chk("rst_resp_carry", 32'(resp_carry), 32'd0);
    chk("rst_txn_cnt", 32'(txn_cnt), 32'd0);
  endtask

  initial begin
    #3;
    reset_checks();
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // 5 + 6 with consumer ready
    step(1, 5, 6, 1);
    chk("pin_5p6_valid", 32'(resp_valid), 32'd1);
    chk("pin_5p6_sum", 32'(resp_sum), 32'd11);
    chk("pin_5p6_carry", 32'(resp_carry), 32'd0);
    step(0, 0, 0, 1);
    chk("pin_txn_after_first", 32'(txn_cnt), 32'd1);

    // 9 + 9 overflows
    step(1, 9, 9, 1);
    chk("pin_9p9_sum", 32'(resp_sum), 32'd2);
`ifdef ADDER_RESPONDER_CARRY_EN
    chk("pin_9p9_carry", 32'(resp_carry), 32'd1);
`else
    chk("pin_9p9_carry", 32'(resp_carry), 32'd0);
`endif
    step(0, 0, 0, 1);

    // Backpressure: fill, hold a third request, then drain in order
    step(1, 1, 1, 0);
    step(1, 2, 2, 0);
    chk("pin_full_ready", 32'(req_ready), 32'd0);
    step(1, 3, 3, 0);
    chk("pin_held_head", 32'(resp_sum), 32'd2);
    step(1, 3, 3, 1);
    chk("pin_second_out", 32'(resp_sum), 32'd4);
    chk("pin_slot_freed", 32'(req_ready), 32'd1);
    step(1, 3, 3, 1);
    chk("pin_third_out", 32'(resp_sum), 32'd6);
    step(0, 0, 0, 1);

    // Simultaneous push and pop at count 1
    step(1, 1, 0, 0);
    step(1, 3, 4, 1);
    chk("pin_pushpop_valid", 32'(resp_valid), 32'd1);
    chk("pin_pushpop_ready", 32'(req_ready), 32'd1);
    chk("pin_pushpop_sum", 32'(resp_sum), 32'd7);
    step(0, 0, 0, 1);

    // Reset pulse between edges with two results buffered
    step(1, 1, 2, 0);
    step(1, 2, 2, 0);
    rst_n = 1'b0;
    model_q.delete();
    model_cnt = 0;
    #1;
    reset_checks();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // 256 back-to-back transactions wrap the counter
    for (int i = 0; i < 257; i++) step(1, $urandom_range(0, MASK), $urandom_range(0, MASK), 1);
    chk("pin_txn_wrap", 32'(txn_cnt), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, MASK), $urandom_range(0, MASK),
           $urandom_range(0, 2) != 0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
